// File: rtl/ray_generator_folded.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ray_generator_folded                                         |
// | Description : Per-pixel primary-ray generator. Builds the camera basis     |
// |               from the forward vector (world up = +Y), forms              |
// |               d = f + u*r + v*up' and, when RAY_GEN_NORMALIZE_EN is        |
// |               defined, normalizes d with a five-step Newton inverse        |
// |               square root. Every multiply goes through one shared signed   |
// |               Q16.16 multiplier, one micro-op per cycle.                   |
// |               Build option: RAY_GEN_NORMALIZE_EN (34-cycle normalized      |
// |               result); when undefined, d is returned after 13 cycles.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ray_generator_folded #(
    parameter int DISPLAY_WIDTH  = 320,
    parameter int DISPLAY_HEIGHT = 240,
    parameter int H_BITS         = 9,
    parameter int V_BITS         = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic [H_BITS-1:0]    hcount_in,
    input  logic [V_BITS-1:0]    vcount_in,
    input  logic [2:0][31:0]     cam_forward_in,
    output logic [2:0][31:0]     ray_direction_out,
    output logic                 valid_out,
    output logic                 ready_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // round(2^16 / H): pixel pitch in Q16.16, fixed at elaboration
    localparam logic signed [31:0] c_inv_h = 32'((65536 + DISPLAY_HEIGHT / 2) / DISPLAY_HEIGHT);
    localparam logic signed [31:0] c_w_m1  = 32'(DISPLAY_WIDTH - 1);
    localparam logic signed [31:0] c_h_m1  = 32'(DISPLAY_HEIGHT - 1);

`ifdef RAY_GEN_NORMALIZE_EN
    localparam logic [5:0]         c_last_step    = 6'd33;
    localparam logic [5:0]         c_newton_first = 6'd15;
    localparam logic [5:0]         c_newton_last  = 6'd29;
    localparam logic signed [31:0] c_three_half   = 32'sd98304;
`else
    localparam logic [5:0]         c_last_step    = 6'd12;
`endif

    function automatic logic signed [63:0] ext64(input logic signed [31:0] a);
        return {{32{a[31]}}, a};
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [63:0] x);
        if (x > 64'sd2147483647)
            return 32'sh7fff_ffff;
        else if (x < -64'sd2147483648)
            return 32'sh8000_0000;
        else
            return x[31:0];
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return sat32(ext64(a) + ext64(b));
    endfunction

    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] a);
        return sat32(64'sd0 - ext64(a));
    endfunction

    state_t             r_state;
    logic [5:0]         r_step;
    logic [H_BITS-1:0]  r_hcount;
    logic [V_BITS-1:0]  r_vcount;
    logic signed [31:0] r_fx, r_fy, r_fz;
    logic signed [31:0] r_u, r_v;
    logic signed [31:0] r_upx, r_upy, r_upz;
    logic signed [31:0] r_dx, r_dy, r_dz;

    logic signed [31:0] w_h_off, w_v_off;
    logic signed [31:0] w_mul_a, w_mul_b, w_prod;
    logic signed [63:0] w_full;

`ifdef RAY_GEN_NORMALIZE_EN
    logic signed [31:0] r_s, r_y, r_t;
    logic [1:0]         r_phase;
    logic               r_zero;
    logic               w_in_newton;
    logic signed [31:0] w_newton_k;
    logic [4:0]         w_msb;
    logic signed [6:0]  w_q, w_m, w_e;
    logic signed [31:0] w_y0;

    assign w_in_newton = (r_step >= c_newton_first) && (r_step <= c_newton_last);
    // Newton correction factor 1.5 - 0.5*s*y^2, halving done as a floor shift
    assign w_newton_k  = sat_add(c_three_half, sat_neg(r_t >>> 1));

    // Leading-one detector: seed y0 = 2^-m, m = floor((k+1)/2), k = msb(s) - 16
    always_comb begin
        w_msb = 5'd0;
        for (int i = 0; i < 31; i++) begin
            if (r_s[i]) w_msb = 5'(i);
        end
        w_q  = $signed({2'b00, w_msb}) - 7'sd15;
        w_m  = w_q >>> 1;
        w_e  = 7'sd16 - w_m;
        w_y0 = 32'sd1 << w_e;
    end
`endif

    // Signed pixel offsets (2h - W + 1) and (H - 1 - 2v) as plain integers
    assign w_h_off = $signed({{(31-H_BITS){1'b0}}, r_hcount, 1'b0}) - c_w_m1;
    assign w_v_off = c_h_m1 - $signed({{(31-V_BITS){1'b0}}, r_vcount, 1'b0});

    // Shared multiplier: 64-bit product, floor shift by 16, clamp to int32
    assign w_full = w_mul_a * w_mul_b;
    assign w_prod = sat32(w_full >>> 16);

    // Operand selection for the current micro-op
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_step)
            6'd0:  begin w_mul_a = w_h_off <<< 16; w_mul_b = c_inv_h;          end
            6'd1:  begin w_mul_a = w_v_off <<< 16; w_mul_b = c_inv_h;          end
            6'd2:  begin w_mul_a = r_fx;           w_mul_b = r_fy;             end
            6'd3:  begin w_mul_a = r_fx;           w_mul_b = r_fx;             end
            6'd4:  begin w_mul_a = r_fz;           w_mul_b = r_fz;             end
            6'd5:  begin w_mul_a = r_fy;           w_mul_b = r_fz;             end
            6'd6:  begin w_mul_a = r_u;            w_mul_b = sat_neg(r_fz);    end
            6'd7:  begin w_mul_a = r_u;            w_mul_b = r_fx;             end
            6'd8:  begin w_mul_a = r_v;            w_mul_b = r_upx;            end
            6'd9:  begin w_mul_a = r_v;            w_mul_b = r_upy;            end
            6'd10: begin w_mul_a = r_v;            w_mul_b = r_upz;            end
`ifdef RAY_GEN_NORMALIZE_EN
            6'd11: begin w_mul_a = r_dx;           w_mul_b = r_dx;             end
            6'd12: begin w_mul_a = r_dy;           w_mul_b = r_dy;             end
            6'd13: begin w_mul_a = r_dz;           w_mul_b = r_dz;             end
            6'd30: begin w_mul_a = r_dx;           w_mul_b = r_y;              end
            6'd31: begin w_mul_a = r_dy;           w_mul_b = r_y;              end
            6'd32: begin w_mul_a = r_dz;           w_mul_b = r_y;              end
`endif
            default: begin
`ifdef RAY_GEN_NORMALIZE_EN
                if (w_in_newton) begin
                    case (r_phase)
                        2'd0:    begin w_mul_a = r_y; w_mul_b = r_y;        end
                        2'd1:    begin w_mul_a = r_s; w_mul_b = r_t;        end
                        default: begin w_mul_a = r_y; w_mul_b = w_newton_k; end
                    endcase
                end
`endif
            end
        endcase
    end

    // Sequencer: capture request, run micro-ops, pulse valid_out for one cycle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state           <= ST_IDLE;
            r_step            <= '0;
            r_hcount          <= '0;
            r_vcount          <= '0;
            r_fx              <= '0;
            r_fy              <= '0;
            r_fz              <= '0;
            r_u               <= '0;
            r_v               <= '0;
            r_upx             <= '0;
            r_upy             <= '0;
            r_upz             <= '0;
            r_dx              <= '0;
            r_dy              <= '0;
            r_dz              <= '0;
`ifdef RAY_GEN_NORMALIZE_EN
            r_s               <= '0;
            r_y               <= '0;
            r_t               <= '0;
            r_phase           <= '0;
            r_zero            <= 1'b0;
`endif
            ray_direction_out <= '0;
            valid_out         <= 1'b0;
            ready_out         <= 1'b1;
        end else begin
            valid_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        r_hcount  <= hcount_in;
                        r_vcount  <= vcount_in;
                        r_fx      <= $signed(cam_forward_in[0]);
                        r_fy      <= $signed(cam_forward_in[1]);
                        r_fz      <= $signed(cam_forward_in[2]);
                        r_step    <= '0;
`ifdef RAY_GEN_NORMALIZE_EN
                        r_phase   <= '0;
`endif
                        ready_out <= 1'b0;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_step <= r_step + 6'd1;
                    case (r_step)
                        6'd0:  r_u   <= w_prod;
                        6'd1:  r_v   <= w_prod;
                        6'd2:  r_upx <= sat_neg(w_prod);
                        6'd3:  r_upy <= w_prod;
                        6'd4:  r_upy <= sat_add(r_upy, w_prod);
                        6'd5:  r_upz <= sat_neg(w_prod);
                        6'd6:  r_dx  <= sat_add(r_fx, w_prod);
                        6'd7:  r_dz  <= sat_add(r_fz, w_prod);
                        6'd8:  r_dx  <= sat_add(r_dx, w_prod);
                        6'd9:  r_dy  <= sat_add(r_fy, w_prod);
                        6'd10: r_dz  <= sat_add(r_dz, w_prod);
`ifdef RAY_GEN_NORMALIZE_EN
                        6'd11: r_s   <= w_prod;
                        6'd12: r_s   <= sat_add(r_s, w_prod);
                        6'd13: r_s   <= sat_add(r_s, w_prod);
                        6'd14: begin
                            r_zero  <= (r_s == '0);
                            r_y     <= (r_s == '0) ? '0 : w_y0;
                            r_phase <= '0;
                        end
                        6'd30: r_dx  <= w_prod;
                        6'd31: r_dy  <= w_prod;
                        6'd32: r_dz  <= w_prod;
`endif
                        default: begin
`ifdef RAY_GEN_NORMALIZE_EN
                            if (w_in_newton) begin
                                case (r_phase)
                                    2'd0: begin
                                        r_t     <= w_prod;
                                        r_phase <= 2'd1;
                                    end
                                    2'd1: begin
                                        r_t     <= w_prod;
                                        r_phase <= 2'd2;
                                    end
                                    default: begin
                                        // a degenerate s leaves y at zero
                                        if (!r_zero) r_y <= w_prod;
                                        r_phase <= 2'd0;
                                    end
                                endcase
                            end
`endif
                        end
                    endcase
                    if (r_step == c_last_step) begin
`ifdef RAY_GEN_NORMALIZE_EN
                        ray_direction_out <= r_zero ? '0 : {r_dz, r_dy, r_dx};
`else
                        ray_direction_out <= {r_dz, r_dy, r_dx};
`endif
                        valid_out <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_out <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    ready_out <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ray_generator_folded.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ray_generator_folded                                      |
// | Description : Self-checking bench for ray_generator_folded. Directed and   |
// |               random requests are compared against an arithmetic model    |
// |               of the ray equations and against a real-valued ideal.       |
// |               Honours RAY_GEN_NORMALIZE_EN like the design.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ray_generator_folded;

    localparam int W = 320;
    localparam int H = 240;
`ifdef RAY_GEN_NORMALIZE_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 13;
`endif

    logic            clk_in   = 1'b0;
    logic            rst_in   = 1'b0;
    logic            valid_in = 1'b0;
    logic [8:0]      hcount_in = '0;
    logic [7:0]      vcount_in = '0;
    logic [2:0][31:0] cam_forward_in = '0;
    logic [2:0][31:0] ray_direction_out;
    logic            valid_out;
    logic            ready_out;

    int n_checks = 0;
    int n_errors = 0;

    ray_generator_folded #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H),
        .H_BITS         (9),
        .V_BITS         (8)
    ) u_dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .valid_in          (valid_in),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .cam_forward_in    (cam_forward_in),
        .ray_direction_out (ray_direction_out),
        .valid_out         (valid_out),
        .ready_out         (ready_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
        longint diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    function automatic longint sat(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic longint fmul(input longint a, input longint b);
        return sat((a * b) >>> 16);
    endfunction

    function automatic longint fadd(input longint a, input longint b);
        return sat(a + b);
    endfunction

    function automatic longint fneg(input longint a);
        return sat(-a);
    endfunction

    // Fixed-point reference: the ray equations evaluated with Q16.16 rules
    task automatic model(input int h, input int v, input longint fx, input longint fy,
                         input longint fz, output longint ox, output longint oy,
                         output longint oz);
        longint invh, u, vv, upx, upy, upz, dx, dy, dz;
`ifdef RAY_GEN_NORMALIZE_EN
        longint s, y, t;
        int p, k, m;
`endif
        invh = longint'($rtoi(65536.0 / H + 0.5));
        u    = longint'(2 * h - W + 1) * invh;
        vv   = longint'(H - 1 - 2 * v) * invh;
        upx  = fneg(fmul(fx, fy));
        upy  = fadd(fmul(fx, fx), fmul(fz, fz));
        upz  = fneg(fmul(fy, fz));
        dx   = fadd(fadd(fx, fmul(u, fneg(fz))), fmul(vv, upx));
        dy   = fadd(fy, fmul(vv, upy));
        dz   = fadd(fadd(fz, fmul(u, fx)), fmul(vv, upz));
`ifdef RAY_GEN_NORMALIZE_EN
        s = fadd(fadd(fmul(dx, dx), fmul(dy, dy)), fmul(dz, dz));
        if (s == 0) begin
            ox = 0; oy = 0; oz = 0;
        end else begin
            p = 0;
            while ((s >> (p + 1)) != 0) p++;
            k = p - 16;
            m = $rtoi($floor((k + 1) / 2.0));
            y = longint'(1) << (16 - m);
            repeat (5) begin
                t = fmul(s, fmul(y, y));
                y = fmul(y, fadd(98304, -(t >>> 1)));
            end
            ox = fmul(dx, y); oy = fmul(dy, y); oz = fmul(dz, y);
        end
`else
        ox = dx; oy = dy; oz = dz;
`endif
    endtask

    // Real-valued ideal of the same geometry (only invH quantized)
    task automatic ideal(input int h, input int v, input real fx, input real fy, input real fz,
                         output real ox, output real oy, output real oz);
        real invh, u, vv, dx, dy, dz;
`ifdef RAY_GEN_NORMALIZE_EN
        real n;
`endif
        invh = $rtoi(65536.0 / H + 0.5) / 65536.0;
        u  = (2 * h - W + 1) * invh;
        vv = (H - 1 - 2 * v) * invh;
        dx = fx + u * (-fz) + vv * (-fx * fy);
        dy = fy + vv * (fx * fx + fz * fz);
        dz = fz + u * fx + vv * (-fy * fz);
`ifdef RAY_GEN_NORMALIZE_EN
        n = $sqrt(dx * dx + dy * dy + dz * dz);
        if (n == 0.0) begin
            ox = 0.0; oy = 0.0; oz = 0.0;
        end else begin
            ox = dx / n; oy = dy / n; oz = dz / n;
        end
`else
        ox = dx; oy = dy; oz = dz;
`endif
    endtask

    task automatic run_req(input string tag, input int h, input int v, input longint fx,
                           input longint fy, input longint fz, input bit poke, input bit use_ideal);
        longint ex, ey, ez;
        real    ix, iy, iz;
        int     n;
        bit     rdy_seen;
        model(h, v, fx, fy, fz, ex, ey, ez);
        @(negedge clk_in);
        valid_in       = 1'b1;
        hcount_in      = 9'(h);
        vcount_in      = 8'(v);
        cam_forward_in = {32'(fz), 32'(fy), 32'(fx)};
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        chk({tag, ".rdy0"}, longint'(ready_out), 0, 0);
        n = 0;
        rdy_seen = 1'b0;
        while (!valid_out && n < 100) begin
            if (poke && n == 4) begin
                valid_in       = 1'b1;
                hcount_in      = 9'd0;
                vcount_in      = 8'd0;
                cam_forward_in = {32'd0, 32'd65536, 32'd0};
            end
            @(posedge clk_in); #1;
            n++;
            valid_in = 1'b0;
            if (ready_out) rdy_seen = 1'b1;
        end
        chk({tag, ".lat"}, n, LAT, 0);
        chk({tag, ".rdybusy"}, longint'(rdy_seen), 0, 0);
        chk({tag, ".x"}, longint'($signed(ray_direction_out[0])), ex, 0);
        chk({tag, ".y"}, longint'($signed(ray_direction_out[1])), ey, 0);
        chk({tag, ".z"}, longint'($signed(ray_direction_out[2])), ez, 0);
        if (use_ideal) begin
            ideal(h, v, fx / 65536.0, fy / 65536.0, fz / 65536.0, ix, iy, iz);
            chk({tag, ".ix"}, longint'($signed(ray_direction_out[0])), longint'($rtoi(ix * 65536.0)), 16);
            chk({tag, ".iy"}, longint'($signed(ray_direction_out[1])), longint'($rtoi(iy * 65536.0)), 16);
            chk({tag, ".iz"}, longint'($signed(ray_direction_out[2])), longint'($rtoi(iz * 65536.0)), 16);
        end
        @(posedge clk_in); #1;
        chk({tag, ".vld1"}, longint'(valid_out), 0, 0);
        chk({tag, ".rdy1"}, longint'(ready_out), 1, 0);
        chk({tag, ".hold"}, longint'($signed(ray_direction_out[0])), ex, 0);
    endtask

    initial begin
        int a, b, c, pulses;
        real nrm;
        longint fx, fy, fz;

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst.rdy", longint'(ready_out), 1, 0);
        chk("rst.vld", longint'(valid_out), 0, 0);
        chk("rst.out", longint'(|ray_direction_out), 0, 0);
        @(negedge clk_in);
        rst_in = 1'b1;

        run_req("ctr",  160, 120, 0,     0, 65536, 1'b0, 1'b1);
        run_req("tl",   0,   0,   0,     0, 65536, 1'b0, 1'b1);
        run_req("fx",   160, 120, 65536, 0, 0,     1'b1, 1'b1);
        run_req("zero", 160, 120, 0,     0, 0,     1'b0, 1'b1);
        run_req("br",   319, 239, 0,     0, 65536, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 2000)) - 1000;
            b = int'($urandom_range(0, 2000)) - 1000;
            c = int'($urandom_range(0, 2000)) - 1000;
            nrm = $sqrt(real'(a * a + b * b + c * c));
            if (nrm < 1.0) begin
                a = 0; b = 0; c = 1000; nrm = 1000.0;
            end
            fx = longint'($rtoi(a / nrm * 65536.0));
            fy = longint'($rtoi(b / nrm * 65536.0));
            fz = longint'($rtoi(c / nrm * 65536.0));
            run_req("rnd", int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                    fx, fy, fz, i[0], 1'b1);
        end

        // Reset in the middle of a request: result discarded, no pulse
        @(negedge clk_in);
        valid_in       = 1'b1;
        hcount_in      = 9'd10;
        vcount_in      = 8'd20;
        cam_forward_in = {32'd65536, 32'd0, 32'd0};
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        repeat (8) @(posedge clk_in);
        #3;
        rst_in = 1'b0;
        #1;
        chk("mrst.rdy", longint'(ready_out), 1, 0);
        chk("mrst.vld", longint'(valid_out), 0, 0);
        chk("mrst.out", longint'(|ray_direction_out), 0, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        pulses = 0;
        repeat (LAT + 10) begin
            @(posedge clk_in); #1;
            if (valid_out) pulses++;
        end
        chk("mrst.pulses", pulses, 0, 0);
        chk("mrst.rdy2", longint'(ready_out), 1, 0);

        run_req("post", 100, 50, 0, 46341, 46341, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
